fft_peak_detector: RTL and testbench
====================================

Name: fft_peak_detector

Overview:
- AXI-Stream sink for the FFT core's master output port; it is the consumer end of the FFT data path, downstream of the input frame generator.
- Per accepted beat it computes the bin power re²+im² and tracks the maximum-power bin over one NFFT-point frame.
- At frame end it reports the peak bin, the peak power and the framing errors through a valid/ready result port.
- Used in simulation and on hardware to check tone frequency on the Cos1..Cos4 test frames.

Parameters:
- DATA_W, 32, width of each signed real/imag component.
- NFFT_LOG2, 14, log2 of frame length (16384 points).
- PWR_W, 2*DATA_W, unsigned power width; holds 2^(2*DATA_W-1) without overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tdata  in  2*DATA_W  FFT bin; [2*DATA_W-1:DATA_W]=re, [DATA_W-1:0]=im, both two's complement.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  sink ready.
- s_tlast  in  1  last bin of frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_peak_bin  out  NFFT_LOG2  index of max-power bin.
- m_peak_pwr  out  PWR_W  power of that bin.
- m_tlast_early  out  1  tlast seen before bin NFFT-1.
- m_tlast_missing  out  1  bin NFFT-1 accepted without tlast.
- m_frame_cnt  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset: all outputs 0, except s_tready=1 one cycle after reset deassertion. State=RUN, bin counter=0, peak registers=0.
- A beat is accepted when s_tvalid && s_tready. Only accepted beats advance the bin counter.
- Power calculation:
  - Stage 1 registers re*re and im*im, signed products.
  - Stage 2 registers their unsigned sum into PWR_W bits.
  - Each pipeline stage carries the bin index and a last flag.
- Peak update on stage-2 output: update only if pwr > peak_pwr (strict). Ties keep the lower bin. Bin 0 always loads as the first candidate.
- Frame close, which sets the last flag:
  - Condition: accepted s_tlast, OR bin counter == NFFT-1.
  - tlast_early = s_tlast && bin < NFFT-1.
  - tlast_missing = bin == NFFT-1 && !s_tlast.
  - The bin counter returns to 0 at close.
- FSM:
  - RUN: s_tready=1. On the accepted closing beat go to DRAIN.
  - DRAIN: s_tready=0. Wait for the last flag to exit stage 2, which takes 2 cycles.
  - REPORT: m_valid=1 with all result fields held stable. s_tready=0. On m_ready go to RUN; in the same cycle clear the peak registers and increment m_frame_cnt.
- Latency: m_valid rises exactly 3 clk after the accepted closing beat.
- Throughput: 1 beat/clk in RUN. Overhead of 3 + (m_ready wait) cycles per frame.
- s_tvalid low mid-frame: the pipeline stalls nothing; bubbles carry no-valid and cause no peak update.
- Reset asserted mid-frame or in REPORT: immediate return to reset values. The partial frame is discarded and m_frame_cnt is not incremented.
- m_ready high outside REPORT is ignored.

Optional Feature:
- Macro FFT_PEAK_HALF_SPECTRUM_EN.
- Defined: only bins 0..NFFT/2-1 are peak candidates. This matches real-only input, which has a conjugate-symmetric spectrum. Upper-half beats are still accepted, counted and framing-checked.
- Undefined: all NFFT bins are candidates.

Decomposition:
- Package fft_sink_pkg holds:
  - the state enum {RUN, DRAIN, REPORT};
  - default DATA_W/NFFT_LOG2 constants;
  - localparam NFFT = 1<<NFFT_LOG2.
- Sub-module fft_pwr_calc: the 2-stage pipelined re²+im² with index/last/valid sideband, instantiated once.

Test Plan:
- Full frame, 16384 beats back-to-back, all bins 0 except bin 1000 = {re=300, im=-400}, tlast on beat 16383 -> m_valid 3 clk after last beat; peak_bin=1000; peak_pwr=250000; both error flags 0.
- Two equal maxima, re=1000 at bins 5 and 9000 -> peak_bin=5.
- Extremes: re=im=-2^31 at bin 7 -> peak_pwr=2^63 exactly, with no overflow.
- tlast at beat 99 -> tlast_early=1 and peak taken from bins 0..99. Then 16384 beats with no tlast -> tlast_missing=1 and the frame closes at beat 16383.
- m_ready held low 20 clk, random s_tvalid gaps during frame -> s_tready=0 throughout DRAIN/REPORT; result stable while held; m_frame_cnt increments once on m_ready.
- rst_n pulsed at beat 8000 -> all outputs 0. A following clean frame with peak at bin 3 reports bin 3 with m_frame_cnt=0->1. With FFT_PEAK_HALF_SPECTRUM_EN, a larger peak at bin 12000 is ignored.

Source files
------------

// File: rtl/fft_sink_pkg.sv
// Shared types and default sizes for the FFT output sink (peak detector).
package fft_sink_pkg;
    localparam int DATA_W_DEF    = 32;
    localparam int NFFT_LOG2_DEF = 14;
    localparam int NFFT          = 1 << NFFT_LOG2_DEF;

    typedef enum logic [1:0] {RUN, DRAIN, REPORT} state_t;
endpackage

// File: rtl/fft_pwr_calc.sv
// Two-stage pipelined bin power re^2 + im^2 with bin index, last flag and valid sideband.
module fft_pwr_calc
    import fft_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = NFFT_LOG2_DEF,
    parameter int PWR_W  = 2*DATA_W
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_p0,
    input  logic                     last_p0,
    input  logic [IDX_W-1:0]         idx_p0,
    input  logic signed [DATA_W-1:0] re_p0,
    input  logic signed [DATA_W-1:0] im_p0,
    output logic                     vld_p2,
    output logic                     last_p2,
    output logic [IDX_W-1:0]         idx_p2,
    output logic [PWR_W-1:0]         pwr_p2
);
    logic                       vld_p1;
    logic                       last_p1;
    logic [IDX_W-1:0]           idx_p1;
    logic signed [2*DATA_W-1:0] sq_re_p1;
    logic signed [2*DATA_W-1:0] sq_im_p1;

    function automatic logic signed [2*DATA_W-1:0] square(input logic signed [DATA_W-1:0] x);
        logic signed [2*DATA_W-1:0] xe;
        xe = (2*DATA_W)'(x);
        return xe * xe;
    endfunction

    // Both squares are non-negative, so the sum is taken as unsigned; (-2^(W-1))^2 * 2 still fits.
    function automatic logic [PWR_W-1:0] pwr_sum(input logic signed [2*DATA_W-1:0] a,
                                                 input logic signed [2*DATA_W-1:0] b);
        return PWR_W'($unsigned(a)) + PWR_W'($unsigned(b));
    endfunction

    // Stage p0 -> p1: squares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && last_p0;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1   <= idx_p0;
        sq_re_p1 <= square(re_p0);
        sq_im_p1 <= square(im_p0);
    end

    // Stage p1 -> p2: power
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        idx_p2 <= idx_p1;
        pwr_p2 <= pwr_sum(sq_re_p1, sq_im_p1);
    end
endmodule

// File: rtl/fft_peak_detector.sv
// AXI-Stream sink finding the max-power bin per FFT frame and reporting it with framing errors.
// Define FFT_PEAK_HALF_SPECTRUM_EN to restrict peak candidates to bins 0..NFFT/2-1.
module fft_peak_detector
    import fft_sink_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
    parameter int PWR_W     = 2*DATA_W
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*DATA_W-1:0]   s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NFFT_LOG2-1:0]  m_peak_bin,
    output logic [PWR_W-1:0]      m_peak_pwr,
    output logic                  m_tlast_early,
    output logic                  m_tlast_missing,
    output logic [15:0]           m_frame_cnt
);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

    state_t                 state;
    logic [NFFT_LOG2-1:0]   bin_cnt;
    logic                   acc;
    logic                   at_last_bin;
    logic                   close;
    logic                   err_early;
    logic                   err_missing;

    logic                   vld_p2;
    logic                   last_p2;
    logic [NFFT_LOG2-1:0]   idx_p2;
    logic [PWR_W-1:0]       pwr_p2;

    logic                   candidate;
    logic                   take;
    logic                   last_p3;
    logic [PWR_W-1:0]       peak_pwr;
    logic [NFFT_LOG2-1:0]   peak_bin;

    assign acc         = s_tvalid && s_tready;
    assign at_last_bin = (bin_cnt == LAST_BIN);
    assign close       = acc && (s_tlast || at_last_bin);

    fft_pwr_calc #(
        .DATA_W (DATA_W),
        .IDX_W  (NFFT_LOG2),
        .PWR_W  (PWR_W)
    ) u_pwr (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_p0  (acc),
        .last_p0 (close),
        .idx_p0  (bin_cnt),
        .re_p0   (s_tdata[2*DATA_W-1:DATA_W]),
        .im_p0   (s_tdata[DATA_W-1:0]),
        .vld_p2  (vld_p2),
        .last_p2 (last_p2),
        .idx_p2  (idx_p2),
        .pwr_p2  (pwr_p2)
    );

`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    assign candidate = !idx_p2[NFFT_LOG2-1];
`else
    assign candidate = 1'b1;
`endif

    // Bin 0 seeds the search; afterwards only a strictly larger power wins, so ties keep the lower bin.
    assign take = vld_p2 && candidate && ((idx_p2 == '0) || (pwr_p2 > peak_pwr));

    // Stage p2 -> p3: running peak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p3  <= 1'b0;
            peak_pwr <= '0;
            peak_bin <= '0;
        end else begin
            last_p3 <= vld_p2 && last_p2;
            if (state == REPORT && m_ready) begin
                peak_pwr <= '0;
                peak_bin <= '0;
            end else if (take) begin
                peak_pwr <= pwr_p2;
                peak_bin <= idx_p2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            s_tready        <= 1'b0;
            bin_cnt         <= '0;
            err_early       <= 1'b0;
            err_missing     <= 1'b0;
            m_valid         <= 1'b0;
            m_peak_bin      <= '0;
            m_peak_pwr      <= '0;
            m_tlast_early   <= 1'b0;
            m_tlast_missing <= 1'b0;
            m_frame_cnt     <= '0;
        end else begin
            case (state)
                RUN: begin
                    s_tready <= 1'b1;
                    if (acc) begin
                        bin_cnt <= close ? '0 : bin_cnt + 1'b1;
                    end
                    if (close) begin
                        state       <= DRAIN;
                        s_tready    <= 1'b0;
                        err_early   <= s_tlast && !at_last_bin;
                        err_missing <= at_last_bin && !s_tlast;
                    end
                end
                DRAIN: begin
                    if (last_p3) begin
                        state           <= REPORT;
                        m_valid         <= 1'b1;
                        m_peak_bin      <= peak_bin;
                        m_peak_pwr      <= peak_pwr;
                        m_tlast_early   <= err_early;
                        m_tlast_missing <= err_missing;
                    end
                end
                REPORT: begin
                    if (m_ready) begin
                        state       <= RUN;
                        m_valid     <= 1'b0;
                        s_tready    <= 1'b1;
                        m_frame_cnt <= m_frame_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    s_tready <= 1'b0;
                    m_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed/randomized frames for fft_peak_detector checked against a max-search reference model.
module tb_fft_peak_detector;
    localparam int DW = 32;
    localparam int NL = 14;
    localparam int NB = 1 << NL;
    localparam int PW = 2*DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*DW-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            s_tlast = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [NL-1:0]   m_peak_bin;
    logic [PW-1:0]   m_peak_pwr;
    logic            m_tlast_early;
    logic            m_tlast_missing;
    logic [15:0]     m_frame_cnt;

    fft_peak_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tlast         (s_tlast),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_peak_bin      (m_peak_bin),
        .m_peak_pwr      (m_peak_pwr),
        .m_tlast_early   (m_tlast_early),
        .m_tlast_missing (m_tlast_missing),
        .m_frame_cnt     (m_frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          re_a [NB];
    int          im_a [NB];
    logic [63:0] exp_pwr;
    int          exp_bin;
    bit          exp_early;
    bit          exp_missing;
    int          exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic abort(input string tag);
        n_fail++;
        $display("FAIL %s: event not seen within bound (observed none, required one)", tag);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "bench aborted");
    endtask

    function automatic logic [63:0] pwr_of(input int re, input int im);
        longint      r;
        longint      i;
        logic [63:0] a;
        logic [63:0] b;
        r = re;
        i = im;
        a = r * r;
        b = i * i;
        return a + b;
    endfunction

    function automatic bit is_cand(input int b);
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
        return b < NB/2;
`else
        return (b >= 0);
`endif
    endfunction

    // Reference: largest power among candidate bins 0..last_idx, lowest index on ties.
    task automatic model(input int last_idx);
        exp_bin = 0;
        exp_pwr = pwr_of(re_a[0], im_a[0]);
        for (int b = 1; b <= last_idx; b++) begin
            if (is_cand(b) && pwr_of(re_a[b], im_a[b]) > exp_pwr) begin
                exp_bin = b;
                exp_pwr = pwr_of(re_a[b], im_a[b]);
            end
        end
    endtask

    task automatic fill(input int amp, input bit full_range);
        for (int i = 0; i < NB; i++) begin
            if (full_range) begin
                re_a[i] = int'($urandom);
                im_a[i] = int'($urandom);
            end else if (amp == 0) begin
                re_a[i] = 0;
                im_a[i] = 0;
            end else begin
                re_a[i] = int'($urandom_range(2*amp)) - amp;
                im_a[i] = int'($urandom_range(2*amp)) - amp;
            end
        end
    endtask

    task automatic send(input int re, input int im, input bit last);
        int guard;
        guard = 0;
        @(negedge clk);
        s_tdata  = {re, im};
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) abort("send_tready");
        end
        @(posedge clk);
    endtask

    // Called right after the closing beat's accepting edge.
    task automatic close_check(input string tag, input int hold);
        int guard;
        #1;
        m_ready = 1'b0;
        check({tag, "_tready_drain"}, s_tready, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_mvalid_at_%0d", tag, k), m_valid, (k == 3));
            check($sformatf("%s_tready_at_%0d", tag, k), s_tready, 1'b0);
        end
        guard = 0;
        while (!m_valid) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 20) abort({tag, "_mvalid"});
        end
        check({tag, "_bin"},     m_peak_bin,      exp_bin);
        check({tag, "_pwr"},     m_peak_pwr,      exp_pwr);
        check({tag, "_early"},   m_tlast_early,   exp_early);
        check({tag, "_missing"}, m_tlast_missing, exp_missing);
        check({tag, "_cnt_pre"}, m_frame_cnt,     exp_cnt);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"},  m_valid,    1'b1);
            check({tag, "_hold_tready"}, s_tready,   1'b0);
            check({tag, "_hold_bin"},    m_peak_bin, exp_bin);
            check({tag, "_hold_pwr"},    m_peak_pwr, exp_pwr);
            check({tag, "_hold_cnt"},    m_frame_cnt, exp_cnt);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        check({tag, "_valid_post"},  m_valid,     1'b0);
        check({tag, "_tready_post"}, s_tready,    1'b1);
        check({tag, "_cnt_post"},    m_frame_cnt, exp_cnt);
    endtask

    // tl_idx < 0 means no tlast in the frame; the frame then closes on bin NB-1.
    task automatic play(input string tag, input int tl_idx, input int gap_pct,
                        input bit mready_run, input int hold);
        int c;
        c           = (tl_idx < 0) ? NB-1 : tl_idx;
        exp_early   = (tl_idx >= 0) && (tl_idx < NB-1);
        exp_missing = (tl_idx < 0);
        model(c);
        m_ready = mready_run;
        for (int i = 0; i <= c; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                s_tvalid = 1'b0;
                s_tdata  = {int'($urandom), int'($urandom)};
            end
            send(re_a[i], im_a[i], (i == tl_idx));
        end
        close_check(tag, hold);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tready"},  s_tready,        1'b0);
        check({tag, "_valid"},   m_valid,         1'b0);
        check({tag, "_bin"},     m_peak_bin,      '0);
        check({tag, "_pwr"},     m_peak_pwr,      '0);
        check({tag, "_early"},   m_tlast_early,   1'b0);
        check({tag, "_missing"}, m_tlast_missing, 1'b0);
        check({tag, "_cnt"},     m_frame_cnt,     '0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_tready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        check("reset_tready_up", s_tready, 1'b1);

        // Single tone, all other bins zero.
        fill(0, 1'b0);
        re_a[1000] = 300;
        im_a[1000] = -400;
        play("tone", NB-1, 0, 1'b0, 0);

        // Equal maxima: lower bin wins.
        fill(0, 1'b0);
        re_a[5]    = 1000;
        re_a[9000] = 1000;
        play("tie", NB-1, 0, 1'b0, 0);

        // Most negative components: full 2^63 power.
        fill(7, 1'b0);
        re_a[7] = int'(32'h8000_0000);
        im_a[7] = int'(32'h8000_0000);
        play("extreme", 15, 0, 1'b0, 0);

        // Early tlast, then a frame that never asserts tlast.
        fill(100, 1'b0);
        re_a[150] = 30000;
        play("early", 99, 0, 1'b0, 0);
        fill(100, 1'b0);
        re_a[NB-1] = 5000;
        play("missing", -1, 0, 1'b0, 0);

        // Random full-range data with bubbles, m_ready high during RUN, result held 20 clk.
        fill(0, 1'b1);
        play("gaps", 299, 30, 1'b1, 20);

        // Reset in the middle of a frame.
        fill(50, 1'b0);
        for (int i = 0; i < 8000; i++) send(re_a[i], im_a[i], 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        check("midreset_release_tready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        check("midreset_tready_up", s_tready, 1'b1);

        // Clean frame: bin 3 peak, larger bin 12000 only counts without the half-spectrum option.
        fill(50, 1'b0);
        re_a[3]     = 20000;
        re_a[12000] = 30000;
        play("after_reset", NB-1, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
